// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester ids, bus widths, and small helpers for range checking and ack
// one-hot generation.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REQ_N  = 2;

    // Requester ids: R0 is the CPU MEM stage, R1 the loader/debug port.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // True when the word index (byte address >> 2) falls outside the memory.
    function automatic logic addr_out_of_range(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       depth_words
    );
        logic [ADDR_W-1:0] word_idx;
        word_idx = {2'b00, addr[ADDR_W-1:2]};
        return (word_idx >= depth_words);
    endfunction

    // One-hot ack vector for a requester id.
    function automatic logic [REQ_N-1:0] grant_onehot(input logic id);
        return (id == REQ_LDR) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the requester-side handshake and the Data_Memory-side bus of the
// arbiter.
//   slave  : the arbiter's view (takes requests and ReadData_i, drives acks,
//            read data, stall and the memory strobes/address/data).
//   master : the environment's view (requesters plus the memory itself).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    // Requester side
    logic [REQ_N-1:0]  req_i;
    logic [REQ_N-1:0]  we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [REQ_N-1:0]  ack_o;
    logic              err_o;
    logic [DATA_W-1:0] rdata_o;
    logic              stall_o;

    // Data_Memory side
    logic              MemRead_o;
    logic              MemWrite_o;
    logic [ADDR_W-1:0] Addr_o;
    logic [DATA_W-1:0] WriteData_o;
    logic [DATA_W-1:0] ReadData_i;

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ReadData_i,
        output ack_o, err_o, rdata_o, stall_o,
               MemRead_o, MemWrite_o, Addr_o, WriteData_o
    );

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ReadData_i,
        input  ack_o, err_o, rdata_o, stall_o,
               MemRead_o, MemWrite_o, Addr_o, WriteData_o
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_rr_pick
// Combinational two-way round-robin picker.
//   req_i        : per-requester request bits
//   last_grant_i : id of the requester served last
//   grant_o      : id of the winner (meaningful only when valid_o=1)
//   valid_o      : at least one request present
// With both requesting, the one not served last wins.
// -----------------------------------------------------------------------------
module dmem_arbiter_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req_i,
    input  logic             last_grant_i,
    output logic             grant_o,
    output logic             valid_o
);

    // Pick the winner from the request pattern and the previous grant.
    always_comb begin
        grant_o = REQ_CPU;
        valid_o = 1'b0;
        case (req_i)
            2'b01: begin
                grant_o = REQ_CPU;
                valid_o = 1'b1;
            end
            2'b10: begin
                grant_o = REQ_LDR;
                valid_o = 1'b1;
            end
            2'b11: begin
                grant_o = ~last_grant_i;
                valid_o = 1'b1;
            end
            default: begin
                grant_o = REQ_CPU;
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port Data_Memory between the CPU MEM stage (R0) and the
// loader/debug port (R1). One access at a time, round-robin between
// requesters, IDLE -> ACCESS -> RESP -> IDLE.
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : req/we/addr/wdata per requester, one-hot ack_o, err_o,
//                  rdata_o, stall_o for the pipeline, and the memory-side
//                  MemRead_o/MemWrite_o/Addr_o/WriteData_o/ReadData_i.
// All outputs except stall_o are registered. Address and write data are
// loaded on the same edge the strobe rises and are held afterwards, so they
// never move while a strobe is high.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned DEPTH_WORDS = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q,        gnt_d;
    logic              we_q,         we_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [REQ_N-1:0]  ack_q,        ack_d;
    logic              err_q,        err_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;

    logic              pick_gnt_s;
    logic              pick_valid_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_oor_s;

    dmem_arbiter_rr_pick u_pick (
        .req_i        (bus.req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_gnt_s),
        .valid_o      (pick_valid_s)
    );

    assign sel_we_s    = bus.we_i[pick_gnt_s];
    assign sel_addr_s  = (pick_gnt_s == REQ_LDR) ? bus.addr1_i  : bus.addr0_i;
    assign sel_wdata_s = (pick_gnt_s == REQ_LDR) ? bus.wdata1_i : bus.wdata0_i;
    assign sel_oor_s   = addr_out_of_range(sel_addr_s, DEPTH_WORDS);

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ack_d        = 2'b00;
        err_d        = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_d = pick_gnt_s;
                    we_d  = sel_we_s;
                    cnt_d = CNT_LOAD;
                    if (sel_oor_s) begin
                        // Out-of-range: skip the memory entirely and answer now.
                        state_d = ST_RESP;
                        ack_d   = grant_onehot(pick_gnt_s);
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else begin
                        state_d     = ST_ACCESS;
                        addr_d      = sel_addr_s;
                        wdata_d     = sel_wdata_s;
                        mem_write_d = sel_we_s;
                        mem_read_d  = ~sel_we_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_RESP;
                    ack_d   = grant_onehot(gnt_q);
                    rdata_d = we_q ? 32'h0000_0000 : bus.ReadData_i;
                end else begin
                    cnt_d       = cnt_q - CNT_ONE;
                    mem_write_d = we_q;
                    mem_read_d  = ~we_q;
                end
            end

            ST_RESP: begin
                state_d      = ST_IDLE;
                last_grant_d = gnt_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_LDR;
            gnt_q        <= REQ_CPU;
            we_q         <= 1'b0;
            cnt_q        <= CNT_ZERO;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.err_o       = err_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.MemRead_o   = mem_read_q;
    assign bus.MemWrite_o  = mem_write_q;
    assign bus.Addr_o      = addr_q;
    assign bus.WriteData_o = wdata_q;
    // The CPU is stalled while it asks and has not yet been answered.
    assign bus.stall_o     = bus.req_i[0] & ~ack_q[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiters: u_dut1 (MEM_LATENCY=1) checked every cycle against a
// transaction-level model, and u_dut4 (MEM_LATENCY=4) for the long-latency
// case. Each drives a small word-addressed memory kept in the bench.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int L1 = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if bus1 ();
    dmem_arbiter_if bus4 ();

    dmem_arbiter #(.MEM_LATENCY(1), .DEPTH_WORDS(9)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    dmem_arbiter #(.MEM_LATENCY(4), .DEPTH_WORDS(9)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    logic [31:0] mem1 [16];
    logic [31:0] mem4 [16];
    logic [31:0] mem_m [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i]  = 32'h1000_0000 + i;
            mem4[i]  = 32'h1000_0000 + i;
            mem_m[i] = 32'h1000_0000 + i;
        end
    end

    assign bus1.ReadData_i = mem1[bus1.Addr_o[5:2]];
    assign bus4.ReadData_i = mem4[bus4.Addr_o[5:2]];

    always @(posedge clk) begin
        if (bus1.MemWrite_o) mem1[bus1.Addr_o[5:2]] <= bus1.WriteData_o;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of u_dut1 ----------------
    int          cyc     = 0;
    int          idle_at = 0;
    int          ack_at  = -1;
    int          win_lo  = -1;
    int          win_hi  = -2;
    logic        m_last  = 1'b1;
    logic        m_win;
    logic [1:0]  m_ack_v = 2'b00;
    logic        m_err   = 1'b0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                idle_at = cyc;
                ack_at  = -1;
                win_lo  = -1;
                win_hi  = -2;
                m_last  = 1'b1;
            end else begin
                if (cyc == ack_at && m_we && !m_err) mem_m[m_addr[5:2]] = m_wdata;
                if (cyc >= idle_at && bus1.req_i != 2'b00) begin
                    if (bus1.req_i == 2'b11) m_win = ~m_last;
                    else                     m_win = bus1.req_i[1];
                    m_last  = m_win;
                    m_we    = bus1.we_i[m_win];
                    m_addr  = m_win ? bus1.addr1_i  : bus1.addr0_i;
                    m_wdata = m_win ? bus1.wdata1_i : bus1.wdata0_i;
                    m_ack_v = m_win ? 2'b10 : 2'b01;
                    m_err   = ((m_addr >> 2) >= 9);
                    if (m_err) begin
                        ack_at  = cyc;
                        win_lo  = -1;
                        win_hi  = -2;
                        m_rdata = 32'h0;
                    end else begin
                        win_lo  = cyc;
                        win_hi  = cyc + L1 - 1;
                        ack_at  = cyc + L1;
                        m_rdata = m_we ? 32'h0 : mem_m[m_addr[5:2]];
                    end
                    idle_at = ack_at + 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare of u_dut1 against the model ----------------
    initial begin
        logic [1:0] e_ack;
        logic       in_win;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ack",   bus1.ack_o,       32'd0);
                chk("rst_err",   bus1.err_o,       32'd0);
                chk("rst_rdata", bus1.rdata_o,     32'd0);
                chk("rst_mr",    bus1.MemRead_o,   32'd0);
                chk("rst_mw",    bus1.MemWrite_o,  32'd0);
                chk("rst_addr",  bus1.Addr_o,      32'd0);
                chk("rst_wd",    bus1.WriteData_o, 32'd0);
            end else begin
                e_ack  = (cyc == ack_at) ? m_ack_v : 2'b00;
                in_win = (cyc >= win_lo) && (cyc <= win_hi);
                chk("ack", bus1.ack_o, e_ack);
                chk("err", bus1.err_o, (cyc == ack_at) ? m_err : 1'b0);
                if (cyc == ack_at) chk("rdata", bus1.rdata_o, m_rdata);
                chk("mem_read",  bus1.MemRead_o,  in_win & ~m_we);
                chk("mem_write", bus1.MemWrite_o, in_win & m_we);
                if (in_win)          chk("addr",  bus1.Addr_o,      m_addr);
                if (in_win && m_we)  chk("wdata", bus1.WriteData_o, m_wdata);
                chk("stall", bus1.stall_o, bus1.req_i[0] & ~e_ack[0]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input logic [1:0] rq, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        bus1.req_i    = rq;
        bus1.we_i     = w;
        bus1.addr0_i  = a0;
        bus1.addr1_i  = a1;
        bus1.wdata0_i = d0;
        bus1.wdata1_i = d1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a nonzero ack on u_dut1; returns negedges waited and the ack.
    task automatic wait_ack(output int n, output logic [1:0] v);
        n = 0;
        v = 2'b00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n++;
            if (bus1.ack_o != 2'b00) begin
                v = bus1.ack_o;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout: got no ack after %0d cycles, required one", n);
    endtask

    initial begin
        int          n;
        int          c_prev;
        int          mr_cnt;
        int          ack_n;
        logic [1:0]  v;
        logic [1:0]  seq [4];
        int          at  [4];
        logic [1:0]  ack4;
        logic [31:0] rd4;

        rst = 1'b1;
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        bus4.req_i = 2'b00; bus4.we_i = 2'b00;
        bus4.addr0_i = 32'h0; bus4.addr1_i = 32'h0;
        bus4.wdata0_i = 32'h0; bus4.wdata1_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("t0_rdata", bus1.rdata_o, 32'h0);
        chk("t0_ack",   bus1.ack_o,   32'h0);

        // 1: write DEADBEEF @0x8 then read it back
        next_edge();
        drv(2'b01, 2'b01, 32'h8, 32'h0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        chk("t1_stall_c0", bus1.stall_o, 32'd1);
        @(negedge clk);
        chk("t1_mw_c1",   bus1.MemWrite_o, 32'd1);
        chk("t1_addr_c1", bus1.Addr_o,     32'h8);
        @(negedge clk);
        chk("t1_ack_c2",  bus1.ack_o,      32'h1);
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        next_edge();
        drv(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_mr_c1", bus1.MemRead_o, 32'd1);
        @(negedge clk);
        chk("t1_rd_ack",   bus1.ack_o,   32'h1);
        chk("t1_rd_rdata", bus1.rdata_o, 32'hDEAD_BEEF);
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // 2: fresh reset, both requesting continuously -> R0,R1,R0,R1, 3 cycles apart
        next_edge();
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        drv(2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(n, v);
            seq[i] = v;
            at[i]  = cyc;
            if (i == 0) chk("t2_rdata0", bus1.rdata_o, 32'h1000_0000);
        end
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t2_g0", seq[0], 32'h1);
        chk("t2_g1", seq[1], 32'h2);
        chk("t2_g2", seq[2], 32'h1);
        chk("t2_g3", seq[3], 32'h2);
        chk("t2_gap1", at[1] - at[0], 32'd3);
        chk("t2_gap3", at[3] - at[2], 32'd3);

        // 4: out-of-range read @0x24 -> immediate ack with err, no strobes
        next_edge();
        drv(2'b01, 2'b00, 32'h24, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_ack",   bus1.ack_o,     32'h1);
        chk("t4_err",   bus1.err_o,     32'd1);
        chk("t4_rdata", bus1.rdata_o,   32'h0);
        chk("t4_mr",    bus1.MemRead_o, 32'd0);
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // 5: reset during a write's ACCESS -> outputs clear at once, no ack, R0 wins next
        next_edge();
        drv(2'b01, 2'b01, 32'h10, 32'h0, 32'h1234_5678, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_mw",   bus1.MemWrite_o,  32'd0);
        chk("t5_addr", bus1.Addr_o,      32'h0);
        chk("t5_wd",   bus1.WriteData_o, 32'h0);
        chk("t5_ack",  bus1.ack_o,       32'h0);
        next_edge();
        rst = 1'b0;
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_noack", bus1.ack_o, 32'h0);
        end
        next_edge();
        drv(2'b11, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        wait_ack(n, v);
        chk("t5_first_r0", v, 32'h1);
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // 6: R0 asks while R1 is in ACCESS -> stalled until its own ack, served next
        next_edge();
        drv(2'b10, 2'b00, 32'h0, 32'h8, 32'h0, 32'h0);
        @(posedge clk);
        #1 drv(2'b11, 2'b00, 32'h0, 32'h8, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_stall_acc", bus1.stall_o, 32'd1);
        @(negedge clk);
        chk("t6_r1_ack",   bus1.ack_o,   32'h2);
        chk("t6_r1_rdata", bus1.rdata_o, 32'hDEAD_BEEF);
        chk("t6_stall_r1", bus1.stall_o, 32'd1);
        next_edge();
        drv(2'b01, 2'b00, 32'h0, 32'h8, 32'h0, 32'h0);
        wait_ack(n, v);
        chk("t6_r0_ack",   v,            32'h1);
        chk("t6_stall_r0", bus1.stall_o, 32'd0);
        next_edge();
        drv(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // 3: MEM_LATENCY=4, R1 read @0xC -> MemRead 4 cycles, ack at cycle 5
        next_edge();
        bus4.req_i = 2'b10; bus4.we_i = 2'b00; bus4.addr1_i = 32'hC;
        mr_cnt = 0;
        ack_n  = 0;
        ack4   = 2'b00;
        rd4    = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("t3_stall", bus4.stall_o, 32'd0);
            if (ack_n == 0) begin
                if (bus4.MemRead_o) mr_cnt++;
                if (bus4.ack_o != 2'b00) begin
                    ack_n = k;
                    ack4  = bus4.ack_o;
                    rd4   = bus4.rdata_o;
                end
            end
        end
        bus4.req_i = 2'b00;
        chk("t3_mr_cycles", mr_cnt,    32'd4);
        chk("t3_ack_cycle", ack_n - 1, 32'd5);
        chk("t3_ack",       ack4,      32'h2);
        chk("t3_rdata",     rd4,       32'h1000_0003);

        c_prev = cyc;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
